// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default sizing for the register file
package regfile_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } rf_state_t;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NRD   = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write bits with per-port lookup
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS  = DEF_NREGS,
    parameter  int NRD    = DEF_NRD,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              claim_en,
    input  logic [AW-1:0]     claim_addr,
    input  logic              rel_en,
    input  logic [AW-1:0]     rel_addr,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREGS-1:0] busy;

    // Claim is applied after release so a same-address pair leaves the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (clr_en) begin
            busy[clr_addr] <= 1'b0;
        end else begin
            if (rel_en) begin
                busy[rel_addr] <= 1'b0;
            end
            if (claim_en) begin
                busy[claim_addr] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_lookup
        logic [AW-1:0] ra;
        logic          fwd;
        assign ra  = rd_addr[k*AW +: AW];
        assign fwd = (BYPASS != 0) && rel_en && (rel_addr == ra)
                     && !(claim_en && (claim_addr == ra));
        assign rd_busy[k] = busy[ra] && !fwd;
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with busy scoreboard and sweep clear
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN   = DEF_XLEN,
    parameter  int NREGS  = DEF_NREGS,
    parameter  int NRD    = DEF_NRD,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_wr_en,
    input  logic [AW-1:0]       i_wr_addr,
    input  logic [XLEN-1:0]     i_wr_data,
    input  logic [NRD*AW-1:0]   i_rd_addr,
    output logic [NRD*XLEN-1:0] o_rd_data,
    output logic [NRD-1:0]      o_rd_busy,
    input  logic                i_claim_en,
    input  logic [AW-1:0]       i_claim_addr,
    input  logic                i_clear,
    output logic                o_ready
);

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    rf_state_t       state;
    rf_state_t       state_nxt;
    logic [AW-1:0]   idx;
    logic            clr_active;
    logic            wr_acc;
    logic            claim_acc;
    logic [XLEN-1:0] regs [NREGS];

    // rst_n gating keeps the forwarding path from leaking data while in reset.
    assign wr_acc    = rst_n && o_ready && !i_clear && i_wr_en && (i_wr_addr != '0);
    assign claim_acc = rst_n && o_ready && !i_clear && i_claim_en && (i_claim_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_clear) state_nxt = ST_CLEAR;
            ST_CLEAR: if (idx == LAST) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ready    = (state == ST_IDLE);
        clr_active = (state == ST_CLEAR);
    end

    // Register 0 is hardwired, so the sweep starts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (o_ready && i_clear) begin
            idx <= AW'(1);
        end else if (clr_active) begin
            idx <= (idx == LAST) ? '0 : idx + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (clr_active) begin
            regs[idx] <= '0;
        end else if (wr_acc) begin
            regs[i_wr_addr] <= i_wr_data;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          fwd;
        assign ra  = i_rd_addr[k*AW +: AW];
        assign fwd = (BYPASS != 0) && wr_acc && (i_wr_addr == ra);
        assign o_rd_data[k*XLEN +: XLEN] = fwd ? i_wr_data : regs[ra];
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .claim_en   (claim_acc),
        .claim_addr (i_claim_addr),
        .rel_en     (wr_acc),
        .rel_addr   (i_wr_addr),
        .clr_en     (clr_active),
        .clr_addr   (idx),
        .rd_addr    (i_rd_addr),
        .rd_busy    (o_rd_busy)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard bench for regfile_sb with and without forwarding
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [9:0]  rd_addr = '0;
    logic        claim_en = 1'b0;
    logic [4:0]  claim_addr = '0;
    logic        clr = 1'b0;

    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  busy_b, busy_n;
    logic        ready_b, ready_n;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_rd_addr(rd_addr), .o_rd_data(rd_data_b),
        .o_rd_busy(busy_b), .i_claim_en(claim_en), .i_claim_addr(claim_addr),
        .i_clear(clr), .o_ready(ready_b)
    );

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) u_nob (
        .clk(clk), .rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_rd_addr(rd_addr), .o_rd_data(rd_data_n),
        .o_rd_busy(busy_n), .i_claim_en(claim_en), .i_claim_addr(claim_addr),
        .i_clear(clr), .o_ready(ready_n)
    );

    // kind: 0/1 data byp/nob, 2/3 busy byp/nob, 4/5 ready byp/nob
    typedef struct {
        string       name;
        int          kind;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string n, input int kind, input int port, input logic [31:0] v);
        exp_t e;
        e.name = n; e.kind = kind; e.port = port; e.exp = v;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ce, input logic [4:0] ca, input logic cl,
                         input logic [4:0] r0, input logic [4:0] r1);
        wr_en = we; wr_addr = wa; wr_data = wd;
        claim_en = ce; claim_addr = ca; clr = cl;
        rd_addr = {r1, r0};
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                0:       act = rd_data_b[e.port*32 +: 32];
                1:       act = rd_data_n[e.port*32 +: 32];
                2:       act = {31'b0, busy_b[e.port]};
                3:       act = {31'b0, busy_n[e.port]};
                4:       act = {31'b0, ready_b};
                default: act = {31'b0, ready_n};
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // in reset: write attempt must not be forwarded
        cyc(); drive(1, 5, 32'h1111_1111, 1, 5, 0, 5, 0);
        push("rst_rd_byp", 0, 0, 0); push("rst_rd_nob", 1, 0, 0);
        push("rst_busy", 2, 0, 0); push("rst_ready_b", 4, 0, 1); push("rst_ready_n", 5, 0, 1);

        cyc(); rst_n = 1'b1; drive(0, 0, 0, 0, 0, 0, 5, 0);
        push("post_rst_rd", 0, 0, 0); push("post_rst_busy", 2, 0, 0);

        cyc(); drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
        push("fwd_x5_byp", 0, 0, 32'hDEADBEEF); push("fwd_x5_nob", 1, 0, 0);
        push("fwd_x5_p1", 0, 1, 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 5, 0);
        push("rd_x5_byp", 0, 0, 32'hDEADBEEF); push("rd_x5_nob", 1, 0, 32'hDEADBEEF);
        push("rd_x0_p1", 0, 1, 0);

        cyc(); drive(1, 7, 32'h12345678, 0, 0, 0, 7, 5);
        push("fwd_x7_byp", 0, 0, 32'h12345678); push("fwd_x7_nob", 1, 0, 0);
        push("fwd_x7_p1", 0, 1, 32'hDEADBEEF);
        cyc(); drive(0, 0, 0, 0, 0, 0, 7, 0);
        push("rd_x7_byp", 0, 0, 32'h12345678); push("rd_x7_nob", 1, 0, 32'h12345678);

        cyc(); drive(0, 0, 0, 1, 3, 0, 3, 0);
        push("claim3_same_b", 2, 0, 0); push("claim3_same_n", 3, 0, 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 3, 0);
        push("claim3_next_b", 2, 0, 1); push("claim3_next_n", 3, 0, 1);
        cyc(); drive(1, 3, 32'h0000_00A5, 0, 0, 0, 3, 0);
        push("wr3_busy_b", 2, 0, 0); push("wr3_busy_n", 3, 0, 1);
        push("wr3_data_b", 0, 0, 32'hA5); push("wr3_data_n", 1, 0, 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 3, 0);
        push("rel3_busy_b", 2, 0, 0); push("rel3_busy_n", 3, 0, 0);
        push("rel3_data_n", 1, 0, 32'hA5);

        cyc(); drive(1, 3, 32'h0000_005A, 1, 3, 0, 3, 0);
        push("cw3_busy_b", 2, 0, 0); push("cw3_data_b", 0, 0, 32'h5A);
        cyc(); drive(0, 0, 0, 0, 0, 0, 3, 0);
        push("cw3_next_b", 2, 0, 1); push("cw3_next_n", 3, 0, 1);
        push("cw3_rd_n", 1, 0, 32'h5A);

        cyc(); drive(1, 3, 32'h77, 1, 6, 0, 3, 6);
        push("c6w3_busy3_b", 2, 0, 0); push("c6w3_busy3_n", 3, 0, 1);
        push("c6w3_busy6_b", 2, 1, 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 3, 6);
        push("c6w3_n3_b", 2, 0, 0); push("c6w3_n6_b", 2, 1, 1); push("c6w3_n6_n", 3, 1, 1);

        cyc(); drive(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 6);
        push("x0_wr_byp", 0, 0, 0); push("x0_busy_b", 2, 0, 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 6);
        push("x0_rd_nob", 1, 0, 0); push("x0_busy_n", 3, 0, 0);

        for (int i = 1; i < 32; i++) begin
            cyc(); drive(1, 5'(i), 32'hC000_0000 | 32'(i), 0, 0, 0, 5'(i), 0);
            push("fill_fwd", 0, 0, 32'hC000_0000 | 32'(i));
        end
        cyc(); drive(0, 0, 0, 1, 6, 0, 6, 9);
        push("fill_rd9", 1, 1, 32'hC000_0009);
        cyc(); drive(0, 0, 0, 0, 0, 0, 6, 0);
        push("reclaim6", 2, 0, 1);

        // clear pulse: same-cycle write and claim are dropped
        cyc(); drive(1, 9, 32'h0000_FFFF, 1, 8, 1, 9, 8);
        push("clr_pulse_ready", 4, 0, 1); push("clr_pulse_nofwd", 0, 0, 32'hC000_0009);
        push("clr_pulse_busy8", 2, 1, 0);
        for (int i = 1; i < 32; i++) begin
            cyc(); drive(1, 5'(i - 1), 32'h0000_0BAD, 1, 31, 1, 5'(i), 5'(i - 1));
            push("clr_ready_b", 4, 0, 0); push("clr_ready_n", 5, 0, 0);
            push("clr_pending", 0, 0, 32'hC000_0000 | 32'(i));
            push("clr_done", 0, 1, 0);
            push("clr_busy", 2, 0, (i == 6) ? 32'd1 : 32'd0);
        end
        cyc(); drive(0, 0, 0, 0, 0, 0, 1, 0);
        push("clr_exit_ready", 4, 0, 1);
        for (int i = 0; i < 32; i++) begin
            cyc(); drive(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
            push("swept_p0_b", 0, 0, 0); push("swept_p1_n", 1, 1, 0);
            push("swept_busy_b", 2, 0, 0); push("swept_busy_n", 3, 1, 0);
        end

        // reset abort at sweep index 10
        cyc(); drive(1, 10, 32'hAAAA_0010, 0, 0, 0, 0, 0);
        cyc(); drive(1, 11, 32'hAAAA_0011, 0, 0, 0, 0, 0);
        cyc(); drive(1, 20, 32'hAAAA_0020, 1, 20, 0, 0, 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 20, 11);
        push("pre_abort_x20", 1, 0, 32'hAAAA_0020); push("pre_abort_busy20", 2, 0, 1);
        cyc(); drive(0, 0, 0, 0, 0, 1, 20, 11);
        for (int i = 1; i < 10; i++) begin
            cyc(); drive(0, 0, 0, 0, 0, 0, 20, 11);
            push("abort_run_ready", 4, 0, 0);
        end
        cyc(); rst_n = 1'b0; drive(0, 0, 0, 0, 0, 0, 20, 11);
        push("abort_ready_b", 4, 0, 1); push("abort_ready_n", 5, 0, 1);
        push("abort_x20", 0, 0, 0); push("abort_x11", 1, 1, 0);
        push("abort_busy20", 2, 0, 0);
        cyc(); rst_n = 1'b1; drive(0, 0, 0, 0, 0, 0, 10, 20);
        push("rel_ready", 4, 0, 1); push("rel_x10", 0, 0, 0); push("rel_x20", 1, 1, 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0);
        push("rel_idle_ready", 4, 0, 1);
        cyc(); drive(1, 12, 32'h0000_0ABC, 0, 0, 0, 12, 0);
        push("post_abort_fwd", 0, 0, 32'hABC);
        cyc(); drive(0, 0, 0, 0, 0, 0, 12, 0);
        push("post_abort_rd_b", 0, 0, 32'hABC); push("post_abort_rd_n", 1, 0, 32'hABC);

        cyc(); cyc();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, register count (power of two, >=4); AW = log2(NREGS).
REQ-003 The block SHALL have parameter NRD, default 2, number of read ports.
REQ-004 The block SHALL have parameter BYPASS, default 1, write-to-read forwarding enable (0/1).
REQ-005 The block SHALL have port clk  in  1  single clock, rising edge.
REQ-006 The block SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port i_wr_en  in  1  write enable.
REQ-008 The block SHALL have port i_wr_addr  in  AW  write address.
REQ-009 The block SHALL have port i_wr_data  in  XLEN  write data.
REQ-010 The block SHALL have port i_rd_addr  in  NRD*AW  packed read addresses, port k at bits [k*AW +: AW].
REQ-011 The block SHALL have port o_rd_data  out  NRD*XLEN  packed read data, port k at [k*XLEN +: XLEN].
REQ-012 The block SHALL have port o_rd_busy  out  NRD  per-port pending-write flag.
REQ-013 The block SHALL have port i_claim_en  in  1  mark destination register pending.
REQ-014 The block SHALL have port i_claim_addr  in  AW  register to mark pending.
REQ-015 The block SHALL have port i_clear  in  1  start clear sequence (single-cycle pulse).
REQ-016 The block SHALL have port o_ready  out  1  high when idle and accepting writes/claims.

Function
REQ-017 Register 0 SHALL always read zero, never be busy; writes/claims to address 0 ignored.
REQ-018 Reads SHALL be combinational, zero latency, all NRD ports independent.
REQ-019 Writes SHALL update the array on the rising clk edge when i_wr_en=1, o_ready=1, i_wr_addr!=0.
REQ-020 With BYPASS=1, a read port whose address equals an accepted same-cycle write address (non-zero) SHALL return i_wr_data; with BYPASS=0 it SHALL return the old contents.
REQ-021 A busy bit per register SHALL set on the edge after an accepted claim and clear on the edge after an accepted write to that address.
REQ-022 Claim and write to the same address in one cycle SHALL leave the bit set (claim wins); to different addresses both take effect.
REQ-023 o_rd_busy[k] SHALL equal the busy bit of i_rd_addr[k]; with BYPASS=1 it SHALL be 0 when a same-cycle accepted write targets that address, unless a same-cycle claim also targets it.
REQ-024 FSM states SHALL be IDLE and CLEAR; o_ready=1 only in IDLE.
REQ-025 IDLE with i_clear=1 SHALL go to CLEAR with index=1; same-cycle write/claim SHALL be ignored.
REQ-026 In CLEAR, each cycle SHALL zero register[index] and its busy bit and increment index; after index NREGS-1 the FSM SHALL return to IDLE (NREGS-1 cycles in CLEAR).
REQ-027 In CLEAR, i_wr_en, i_claim_en, i_clear SHALL be ignored; reads SHALL return current (partially cleared) contents with no bypass.

Reset
REQ-028 rst_n low SHALL asynchronously zero all registers and busy bits, set FSM IDLE, index 0, o_ready=1.
REQ-029 Reset asserted mid-CLEAR SHALL abort the sequence; first edge after release SHALL be IDLE.
REQ-030 During reset o_rd_data SHALL read all zero and o_rd_busy all zero.

Structure
REQ-031 Package regfile_pkg SHALL hold the FSM state enum and default XLEN/NREGS/NRD constants.
REQ-032 Busy-bit tracking SHALL be a sub-module regfile_scoreboard (claim/release/clear/lookup); data array and FSM stay in regfile_sb.

Verification
REQ-033 Reset release, write x5=0xDEADBEEF, next cycle read port0 addr 5 -> 0xDEADBEEF, port1 addr 0 -> 0.
REQ-034 BYPASS=1: write x7=0x12345678 while port0 reads 7 -> same-cycle 0x12345678; BYPASS=0 -> old value 0.
REQ-035 Claim x3, next cycle o_rd_busy[0]=1 for addr 3; write x3=0xA5 -> busy 0 next cycle; claim+write x3 same cycle -> busy stays 1.
REQ-036 Fill x1..x31 with non-zero, pulse i_clear -> o_ready=0 for 31 cycles, all reads 0 afterwards, write during CLEAR has no effect.
REQ-037 Assert rst_n low at CLEAR index 10 -> all registers 0, o_ready=1 immediately, FSM IDLE after release.
